// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and the ahb_timer register map
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [11:0] TMR_CTRL   = 12'h000;
  localparam logic [11:0] TMR_LOAD   = 12'h004;
  localparam logic [11:0] TMR_VALUE  = 12'h008;
  localparam logic [11:0] TMR_STATUS = 12'h00C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int CTRL_RELOAD = 2;
  localparam int CTRL_PS_LSB = 8;
  localparam int CTRL_PS_MSB = 15;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_WAIT,
    BUS_ERR1,
    BUS_ERR2
  } bus_state_e;

  // Word-sized, word-aligned and inside the four-register window.
  function automatic logic tmr_access_ok(input logic [11:0] offset, input logic [2:0] size);
    return (size == HSIZE_WORD) && (offset[1:0] == 2'b00) && (offset <= TMR_STATUS);
  endfunction

endpackage

// File: rtl/ahb_timer_core.sv
// rtl/ahb_timer_core.sv - down-counter, prescaler, FLAG and reload behind decoded write strobes
// AHB_TIMER_PRESCALER_EN adds the CTRL.PRESCALE field and tick divider.
module ahb_timer_core
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] value_rd,
  output logic        flag,
  output logic        irq
);

  logic        en;
  logic        irqen;
  logic        reload;
  logic [31:0] load_q;
  logic [31:0] value_q;
  logic        flag_q;
  logic        irq_q;
  logic        tick;
  logic        zero_tick;

`ifdef AHB_TIMER_PRESCALER_EN
  logic [7:0] prescale;
  logic [7:0] pre_cnt;

  assign tick    = en && (pre_cnt == prescale);
  assign ctrl_rd = {16'h0, prescale, 5'h0, reload, irqen, en};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_ctrl)
        prescale <= wdata[CTRL_PS_MSB:CTRL_PS_LSB];
      if (!en || wr_load || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + 8'd1;
    end
  end
`else
  assign tick    = en;
  assign ctrl_rd = {29'h0, reload, irqen, en};
`endif

  assign zero_tick = tick && (value_q == '0);

  // Bus writes are applied after the tick so they override it; FLAG set still beats W1C.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      en      <= 1'b0;
      irqen   <= 1'b0;
      reload  <= 1'b0;
      load_q  <= '0;
      value_q <= '0;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (zero_tick) begin
        if (reload)
          value_q <= load_q;
        else
          en <= 1'b0;
      end else if (tick) begin
        value_q <= value_q - 32'd1;
      end
      if (wr_load) begin
        load_q  <= wdata;
        value_q <= wdata;
      end
      if (wr_ctrl) begin
        en     <= wdata[CTRL_EN];
        irqen  <= wdata[CTRL_IRQEN];
        reload <= wdata[CTRL_RELOAD];
      end
      if (wr_status && wdata[0])
        flag_q <= 1'b0;
      if (zero_tick)
        flag_q <= 1'b1;
      irq_q <= flag_q & irqen;
    end
  end

  assign load_rd  = load_q;
  assign value_rd = value_q;
  assign flag     = flag_q;
  assign irq      = irq_q;

endmodule

// File: rtl/ahb_timer.sv
// rtl/ahb_timer.sv - AHB-Lite slave front end for the 32-bit reload timer
// Optional AHB_TIMER_PRESCALER_EN (see ahb_timer_core) enables the tick prescaler.
module ahb_timer
  import ahb_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        IRQ
);

  localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WCW-1:0] WCNT_INIT = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  bus_state_e     state;
  bus_state_e     state_nxt;
  logic [WCW-1:0] wcnt;
  logic           dp_pend;
  logic           dp_write;
  logic [3:0]     dp_off;
  logic           accept;
  logic           access_ok;
  logic           complete;
  logic           wr_ctrl;
  logic           wr_load;
  logic           wr_status;
  logic [31:0]    ctrl_rd;
  logic [31:0]    load_rd;
  logic [31:0]    value_rd;
  logic           flag;
  logic           unused_bits;

  assign unused_bits = ^{HADDR[31:12], HTRANS[0]};

  // New address phases are only taken in cycles where this slave drives HREADYOUT high.
  assign accept    = HSEL && HTRANS[1] && HREADY && (state == BUS_IDLE || state == BUS_ERR2);
  assign access_ok = tmr_access_ok(HADDR[11:0], HSIZE);
  assign complete  = dp_pend && (state == BUS_IDLE);

  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      state <= BUS_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wcnt     <= '0;
      dp_pend  <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
    end else begin
      if (accept) begin
        dp_pend  <= access_ok;
        dp_write <= HWRITE;
        dp_off   <= HADDR[3:0];
      end else if (complete) begin
        dp_pend <= 1'b0;
      end
      if (state != BUS_WAIT)
        wcnt <= WCNT_INIT;
      else
        wcnt <= wcnt - WCW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BUS_IDLE, BUS_ERR2: begin
        state_nxt = BUS_IDLE;
        if (accept) begin
          if (!access_ok)
            state_nxt = BUS_ERR1;
          else if (WAIT_STATES > 0)
            state_nxt = BUS_WAIT;
        end
      end
      BUS_WAIT: if (wcnt == '0) state_nxt = BUS_IDLE;
      BUS_ERR1: state_nxt = BUS_ERR2;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    wr_ctrl   = 1'b0;
    wr_load   = 1'b0;
    wr_status = 1'b0;
    case (state)
      BUS_WAIT: HREADYOUT = 1'b0;
      BUS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      BUS_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
    if (complete && dp_write) begin
      wr_ctrl   = (dp_off == TMR_CTRL[3:0]);
      wr_load   = (dp_off == TMR_LOAD[3:0]);
      wr_status = (dp_off == TMR_STATUS[3:0]);
    end
    if (complete && !dp_write) begin
      case (dp_off)
        TMR_CTRL[3:0]:   HRDATA = ctrl_rd;
        TMR_LOAD[3:0]:   HRDATA = load_rd;
        TMR_VALUE[3:0]:  HRDATA = value_rd;
        TMR_STATUS[3:0]: HRDATA = {31'h0, flag};
        default:         HRDATA = '0;
      endcase
    end
  end

  ahb_timer_core u_core (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .wr_ctrl  (wr_ctrl),
    .wr_load  (wr_load),
    .wr_status(wr_status),
    .wdata    (HWDATA),
    .ctrl_rd  (ctrl_rd),
    .load_rd  (load_rd),
    .value_rd (value_rd),
    .flag     (flag),
    .irq      (IRQ)
  );

endmodule

// File: doc/ahb_timer.md
# ahb_timer

AHB-Lite slave carrying a 32-bit down-counting timer with reload and interrupt. It sits on one slave port of the system AHB interconnect and is selected by its HSEL line. It returns HREADYOUT/HRDATA/HRESP into the interconnect's response mux. It supports programmable data-phase wait states and a two-cycle ERROR response for illegal accesses.

## Interface
- WAIT_STATES, 0: extra data-phase cycles (HREADYOUT low) inserted on every legal transfer
- HCLK  in  1  system clock; all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select from interconnect decoder
- HADDR  in  32  address; only HADDR[11:0] decoded
- HTRANS  in  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size; only 3'b010 (word) legal
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-wide ready from interconnect
- HREADYOUT  out  1  this slave's ready
- HRDATA  out  32  read data
- HRESP  out  1  0 = OKAY, 1 = ERROR
- IRQ  out  1  interrupt, level, registered

## Operation
- Registers (offset = HADDR[11:0]):
  - 0x0 CTRL: [0] EN, [1] IRQEN, [2] RELOAD, [15:8] PRESCALE (see Configuration); other bits read 0.
  - 0x4 LOAD: RW. A write also copies the data into VALUE.
  - 0x8 VALUE: read-only. A write is ignored and returns OKAY.
  - 0xC STATUS: [0] FLAG. Writing 1 clears it; writing 0 has no effect.
- Address phase accepted when HSEL & HTRANS[1] & HREADY. The slave captures HADDR[11:0], HWRITE and HSIZE.
- IDLE/BUSY transfers, or HSEL low: zero-wait OKAY response, no register effect.
- Illegal access → ERROR response, no register effect. Illegal means any of:
  - HSIZE ≠ 010
  - HADDR[1:0] ≠ 0
  - offset > 0xC
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. On a legal accept, go to WAIT if WAIT_STATES>0, otherwise stay in IDLE and complete next cycle. On an illegal accept, go to ERR1.
  - WAIT: HREADYOUT=0 for WAIT_STATES cycles (down-counter), then one HREADYOUT=1 completion cycle, then IDLE. A new accept in the completion cycle is honoured (back-to-back).
  - ERR1: HREADYOUT=0, HRESP=1, go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept in this cycle is honoured; otherwise go to IDLE.
- Write commit: HWDATA is sampled on the completion cycle (HREADYOUT=1) of the data phase.
- Read data: HRDATA is driven with the register value during the completion cycle. It is 0 in all other cycles, including errors.
- Timer:
  - When EN=1, each tick decrements VALUE.
  - A tick with VALUE==0 sets FLAG.
  - On that tick, if RELOAD=1, VALUE←LOAD. If RELOAD=0, EN←0 and VALUE stays 0.
  - VALUE wraps only via reload; it never decrements below 0.
- IRQ = FLAG & IRQEN, taken from registered state.
- Simultaneous events:
  - Hardware FLAG set and software W1C in the same cycle: set wins.
  - LOAD write and a tick in the same cycle: the write wins; VALUE = new LOAD and the prescaler restarts.
  - CTRL write clearing EN and a zero tick in the same cycle: the write wins, but FLAG is still set.

## Timing
- Reset (HRESETn low at a rising edge):
  - FSM → IDLE
  - HREADYOUT=1, HRESP=0, HRDATA=0, IRQ=0
  - all registers and the prescaler counter = 0
- Reset asserted mid-transfer aborts it with no register update.
- Read latency: data appears WAIT_STATES+1 cycles after the address phase.
- Error: exactly two data-phase cycles, independent of WAIT_STATES.
- IRQ rises the cycle after FLAG sets (registered). It falls the cycle after the W1C completion.

## Configuration
- AHB_TIMER_PRESCALER_EN defined:
  - CTRL[15:8] is RW.
  - A tick occurs every PRESCALE+1 HCLK cycles while EN=1.
  - The prescaler counter clears when EN=0 or LOAD is written.
- Not defined:
  - CTRL[15:8] reads 0 and writes are ignored.
  - A tick occurs every cycle while EN=1.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY/HRESP_ERROR
  - HSIZE_WORD
  - timer register offset constants and CTRL bit indices
- Sub-module ahb_timer_core holds the counter, prescaler, FLAG logic and reload. It is driven by decoded write strobes from the bus FSM in ahb_timer.

## Test plan
- Reset, then read 0x8 with WAIT_STATES=0 → HRDATA=0, HRESP=0, completes 1 cycle after the address phase.
- Write LOAD=5, write CTRL=0x7 → VALUE reads 4,3,…; FLAG sets after 6 ticks, VALUE reloads to 5, IRQ=1 next cycle. W1C 0xC=1 → IRQ=0.
- One-shot: LOAD=2, CTRL=0x1 → after the zero tick, EN=0, VALUE=0, FLAG=1, no further change.
- Illegal accesses → two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1, HRDATA=0), registers unchanged:
  - HSIZE=000 write to 0x4
  - read of 0x10
  - HADDR=0x6
- WAIT_STATES=3, back-to-back NONSEQ write 0x4 then read 0x4 → each transfer holds HREADYOUT low for 3 cycles. The read returns the written value.
- With AHB_TIMER_PRESCALER_EN, PRESCALE=3, LOAD=1 → FLAG after 8 HCLK. Hardware set coincident with W1C → FLAG remains 1.
